// File: rtl/gray2bin_arbiter.sv
// Two-requester round-robin arbiter feeding one registered Gray-to-binary stage.
// The result slot is a single-entry buffer with a valid/ready output handshake.
module gray2bin_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_gray,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_gray,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_binary,
  output logic             out_id,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             prio;
  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] sel_gray;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The slot can take a new code when empty, or when the current result leaves this cycle.
  assign can_accept = (state == EMPTY) | out_ready;
  assign grant0     = req0_valid & (~req1_valid | ~prio);
  assign grant1     = req1_valid & (~req0_valid | prio);
  assign req0_ready = can_accept & grant0;
  assign req1_ready = can_accept & grant1;
  assign accept     = req0_ready | req1_ready;
  assign sel_gray   = req1_ready ? req1_gray : req0_gray;
  assign out_valid  = (state == FULL);

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Priority moves to the other requester after every accept, so a lone requester still toggles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      prio       <= 1'b0;
      out_binary <= '0;
      out_id     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        out_binary <= gray_to_bin(sel_gray);
        out_id     <= req1_ready;
        prio       <= ~req1_ready;
      end
    end
  end

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Self-checking bench for gray2bin_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_gray2bin_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_gray;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_gray;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_binary;
  logic             out_id;
  logic             out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  gray2bin_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_gray  (req0_gray),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_gray  (req1_gray),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_binary (out_binary),
    .out_id     (out_id),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion: binary is the XOR of the Gray code with all of its right shifts.
  function automatic logic [WIDTH-1:0] ref_conv(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_gray  = '0;
    req1_gray  = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({out_valid, out_id, out_binary, req0_ready, req1_ready} !== 8'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %b want %b",
               {out_valid, out_id, out_binary, req0_ready, req1_ready}, 8'b0);
    end
    req0_valid = 1'b1;
    req0_gray  = 4'hC;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_binary} !== {1'b1, 4'h8}) begin
      n_fail++;
      $display("[TB] FAIL reset_prefill: got %b want %b", {out_valid, out_binary}, {1'b1, 4'h8});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_id, out_binary} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got %b want %b", {out_valid, out_id, out_binary}, 6'b0);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req0_valid = 1'b1;
    req0_gray  = 4'h3;
    req1_valid = 1'b1;
    req1_gray  = 4'h8;
    out_ready  = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, req0_ready, req1_ready} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL reset_first_grant: got %b want %b", {out_valid, req0_ready, req1_ready}, 3'b010);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_id, out_binary} !== {1'b1, 1'b0, 4'h2}) begin
      n_fail++;
      $display("[TB] FAIL reset_first_result: got %b want %b",
               {out_valid, out_id, out_binary}, {1'b1, 1'b0, 4'h2});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] gin [0:2];
    logic [WIDTH-1:0] gexp [0:2];
    gin[0] = 4'hF; gin[1] = 4'h6; gin[2] = 4'hC;
    gexp[0] = 4'hA; gexp[1] = 4'h4; gexp[2] = 4'h8;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1;
      req0_gray  = gin[i];
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        n_fail++;
        $display("[TB] FAIL single_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, 2'b10);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_id, out_binary} !== {1'b1, 1'b0, gexp[i]}) begin
        n_fail++;
        $display("[TB] FAIL single_out[%0d]: got %b want %b", i,
                 {out_valid, out_id, out_binary}, {1'b1, 1'b0, gexp[i]});
      end
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] want;
    logic             wid;
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_gray  = 4'h3;
    req1_valid = 1'b1;
    req1_gray  = 4'h8;
    for (int k = 0; k < 4; k++) begin
      wid  = k[0];
      want = wid ? 4'hF : 4'h2;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== {~wid, wid}) begin
        n_fail++;
        $display("[TB] FAIL contention_ready[%0d]: got %b want %b", k, {req0_ready, req1_ready}, {~wid, wid});
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_id, out_binary} !== {1'b1, wid, want}) begin
        n_fail++;
        $display("[TB] FAIL contention_out[%0d]: got %b want %b", k,
                 {out_valid, out_id, out_binary}, {1'b1, wid, want});
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_gray  = 4'hF;
    @(posedge clk);
    #1;
    req0_gray  = 4'h3;
    req1_valid = 1'b1;
    req1_gray  = 4'h8;
    out_ready  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL hold_ready[%0d]: got %b want %b", k, {req0_ready, req1_ready}, 2'b00);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_id, out_binary} !== {1'b1, 1'b0, 4'hA}) begin
        n_fail++;
        $display("[TB] FAIL hold_out[%0d]: got %b want %b", k,
                 {out_valid, out_id, out_binary}, {1'b1, 1'b0, 4'hA});
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL release_ready: got %b want %b", {req0_ready, req1_ready}, 2'b01);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_id, out_binary} !== {1'b1, 1'b1, 4'hF}) begin
      n_fail++;
      $display("[TB] FAIL release_out: got %b want %b", {out_valid, out_id, out_binary}, {1'b1, 1'b1, 4'hF});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] tbl [0:15];
    logic [WIDTH-1:0] g;
    tbl[0]  = 4'h0; tbl[1]  = 4'h1; tbl[2]  = 4'h3; tbl[3]  = 4'h2;
    tbl[4]  = 4'h7; tbl[5]  = 4'h6; tbl[6]  = 4'h4; tbl[7]  = 4'h5;
    tbl[8]  = 4'hF; tbl[9]  = 4'hE; tbl[10] = 4'hC; tbl[11] = 4'hD;
    tbl[12] = 4'h8; tbl[13] = 4'h9; tbl[14] = 4'hB; tbl[15] = 4'hA;
    do_reset();
    out_ready  = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      g         = i[WIDTH-1:0];
      req1_gray = g;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        n_fail++;
        $display("[TB] FAIL sweep_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, 2'b01);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_id, out_binary} !== {1'b1, 1'b1, tbl[i]}) begin
        n_fail++;
        $display("[TB] FAIL sweep_out[%0d]: got %b want %b", i,
                 {out_valid, out_id, out_binary}, {1'b1, 1'b1, tbl[i]});
      end
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_gray  = 4'h6;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    n_cmp++;
    if ({out_valid, out_binary} !== {1'b1, 4'h4}) begin
      n_fail++;
      $display("[TB] FAIL drain_first: got %b want %b", {out_valid, out_binary}, {1'b1, 4'h4});
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL drain_empty[%0d]: got %b want %b", k, out_valid, 1'b0);
      end
    end
  endtask

  // Transaction-level model: one result slot, a priority token, and requesters that hold until served.
  task automatic test_random();
    logic             m_full;
    logic [WIDTH-1:0] m_bin;
    logic             m_id;
    logic             m_prio;
    int               win;
    logic             acc0;
    logic             acc1;
    do_reset();
    m_full = 1'b0;
    m_bin  = '0;
    m_id   = 1'b0;
    m_prio = 1'b0;
    acc0   = 1'b0;
    acc1   = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++;
      if (out_valid !== m_full || (m_full && {out_id, out_binary} !== {m_id, m_bin})) begin
        n_fail++;
        $display("[TB] FAIL rand_out[%0d]: got %b want %b", cyc,
                 {out_valid, out_id, out_binary}, {m_full, m_id, m_bin});
      end
      if (acc0 || !req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_gray  = WIDTH'($urandom);
      end
      if (acc1 || !req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_gray  = WIDTH'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = -1;
      if (!m_full || out_ready) begin
        if (req0_valid && req1_valid) win = m_prio ? 1 : 0;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
      end
      acc0 = (win == 0);
      acc1 = (win == 1);
      n_cmp++;
      if ({req0_ready, req1_ready} !== {acc0, acc1}) begin
        n_fail++;
        $display("[TB] FAIL rand_ready[%0d]: got %b want %b", cyc, {req0_ready, req1_ready}, {acc0, acc1});
      end
      if (win >= 0) begin
        m_full = 1'b1;
        m_bin  = ref_conv(acc1 ? req1_gray : req0_gray);
        m_id   = acc1;
        m_prio = ~acc1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_sweep();
    test_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gray2bin_arbiter.md
Name: gray2bin_arbiter

Overview:
- Shares one registered Gray-to-binary conversion stage between two requesters.
- Each requester presents a Gray code with a valid/ready handshake. The block arbitrates round-robin, converts the code, and presents the binary result with the winning requester's ID on a single valid/ready output port.
- Sits between upstream Gray-coded sources (encoder or CDC pointer logic) and downstream binary consumers.

Parameters:
- WIDTH, 4, bit width of Gray input and binary output (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a Gray code.
- req0_gray  input  WIDTH  requester 0 Gray code.
- req0_ready  output  1  requester 0 code accepted this cycle.
- req1_valid  input  1  requester 1 has a Gray code.
- req1_gray  input  WIDTH  requester 1 Gray code.
- req1_ready  output  1  requester 1 code accepted this cycle.
- out_valid  output  1  result slot holds a result.
- out_binary  output  WIDTH  converted binary value.
- out_id  output  1  requester that produced out_binary (0/1).
- out_ready  input  1  downstream takes the result this cycle.

Behaviour:
- Reset (async, rst_n low):
  - Immediately clears out_valid=0, out_binary=0, out_id=0, prio=0 and state=EMPTY.
  - Outputs hold these values while rst_n is low.
  - A result in flight at reset is discarded and never presented.
- Conversion:
  - bin[WIDTH-1]=gray[WIDTH-1]; bin[i]=bin[i+1]^gray[i] for i=WIDTH-2..0.
  - Purely combinational ahead of the output register; no width growth.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and no accept.
  - FULL -> FULL when out_ready=1 with accept (back-to-back), or when out_ready=0 (hold).
- Accept condition: can_accept = (state==EMPTY) | out_ready.
- Grant logic:
  - grant0 = req0_valid & (~req1_valid | prio==0).
  - grant1 = req1_valid & (~req0_valid | prio==1).
  - req0_ready = can_accept & grant0; req1_ready = can_accept & grant1.
  - The readys are combinational and depend on valids.
  - Readys are never both 1, and are 0 when their valid is 0.
- Accept (at the clk edge where reqN_valid & reqN_ready):
  - out_binary <= conv(reqN_gray); out_id <= N.
  - prio <= ~N, i.e. the loser or the other requester gets priority next.
- prio is unchanged in cycles with no accept, including cycles where requests are stalled.
- Latency and throughput:
  - Result appears on the output one cycle after accept.
  - Sustained throughput is one result per cycle when out_ready=1.
- Hold: while out_valid=1 and out_ready=0, out_binary and out_id stay stable and both readys are 0.
- Fairness: with both valids held high and out_ready=1, grants strictly alternate 0,1,0,1.
- Single requester: a lone valid requester is granted every cycle regardless of prio, and prio flips each accept.
- Requester contract: a requester must hold valid and gray stable until ready. The block does not check this.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid drops to 0 without waiting for clk; after release, first grant goes to req0 when both are valid.
- Single requester, WIDTH=4, out_ready=1: req0 sends 4'hF, 4'h6, 4'hC on consecutive cycles -> out_binary 4'hA, 4'h4, 4'h8 with out_id=0 on consecutive cycles, one cycle after each accept.
- Contention: both valid continuously with req0_gray=4'h3 and req1_gray=4'h8, out_ready=1 -> outputs alternate (0,4'h2),(1,4'hF),(0,4'h2),(1,4'hF).
- Backpressure: out_ready=0 for 3 cycles with a result 4'hA held and both requesters valid -> out_binary/out_id stable, readys 0. When out_ready rises, the pending request is accepted in the same cycle and the new result follows next cycle.
- Exhaustive conversion: req1 alone sweeps gray 4'h0..4'hF -> outputs 0,1,3,2,7,6,4,5,F,E,C,D,8,9,B,A.
- Drain: a single accept, then out_ready=1 with no valids -> out_valid is high for exactly one cycle, then 0.
